// File: rtl/exc_vector_loader.sv
// Exception entry sequencer: save EPC, steer the read address to the cause's vector byte, load it into PC; busy for MEM_LAT+2 cycles.
// Requests that arrive while busy are dropped, or held in a one-deep slot when EXC_PENDING_EN is defined.
module exc_vector_loader #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        exc_req,
  input  logic [1:0]  exc_cause,
  input  logic [31:0] pc_in,
  input  logic [7:0]  mem_data,
  output logic [2:0]  iord_sel,
  output logic        epc_wr,
  output logic [31:0] epc_out,
  output logic        pc_wr,
  output logic [31:0] pc_out,
  output logic [1:0]  cause_out,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SAVE = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_LOAD = 2'd3;

  localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] pc_q, pc_d;

  logic        live_ok;
  logic        acc;
  logic [1:0]  acc_cause;
  logic [31:0] acc_pc;

`ifdef EXC_PENDING_EN
  logic        pend_vld_q, pend_vld_d;
  logic [1:0]  pend_cause_q, pend_cause_d;
  logic [31:0] pend_pc_q, pend_pc_d;
`endif

  assign live_ok = exc_req && (exc_cause != 2'b11);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    pc_d      = pc_q;
    acc       = 1'b0;
    acc_cause = exc_cause;
    acc_pc    = pc_in;
`ifdef EXC_PENDING_EN
    pend_vld_d   = pend_vld_q;
    pend_cause_d = pend_cause_q;
    pend_pc_d    = pend_pc_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef EXC_PENDING_EN
        // The held request goes first; a live one in the same cycle takes its slot.
        if (pend_vld_q) begin
          acc        = 1'b1;
          acc_cause  = pend_cause_q;
          acc_pc     = pend_pc_q;
          pend_vld_d = live_ok;
          if (live_ok) begin
            pend_cause_d = exc_cause;
            pend_pc_d    = pc_in;
          end
        end else begin
          acc = live_ok;
        end
`else
        acc = live_ok;
`endif
        if (acc) begin
          state_d = S_SAVE;
          cause_d = acc_cause;
          epc_d   = acc_pc - 32'd4;
        end
      end
      S_SAVE: begin
        state_d = S_WAIT;
        cnt_d   = CNT_INIT;
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = {24'b0, mem_data};
      end
    endcase
`ifdef EXC_PENDING_EN
    if ((state_q != S_IDLE) && live_ok && !pend_vld_q) begin
      pend_vld_d   = 1'b1;
      pend_cause_d = exc_cause;
      pend_pc_d    = pc_in;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      cause_q <= 2'd0;
      epc_q   <= 32'd0;
      pc_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      pc_q    <= pc_d;
    end
  end

`ifdef EXC_PENDING_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_vld_q   <= 1'b0;
      pend_cause_q <= 2'd0;
      pend_pc_q    <= 32'd0;
    end else begin
      pend_vld_q   <= pend_vld_d;
      pend_cause_q <= pend_cause_d;
      pend_pc_q    <= pend_pc_d;
    end
  end
`endif

  always_comb begin
    iord_sel = 3'b000;
    if (state_q != S_IDLE) begin
      case (cause_q)
        2'b00:   iord_sel = 3'b010;
        2'b01:   iord_sel = 3'b011;
        2'b10:   iord_sel = 3'b100;
        default: iord_sel = 3'b000;
      endcase
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign epc_wr    = (state_q == S_SAVE);
  assign pc_wr     = (state_q == S_LOAD);
  assign done      = (state_q == S_LOAD);
  assign epc_out   = epc_q;
  assign cause_out = cause_q;
  // The vector byte is only valid in LOAD, so it is forwarded straight through that cycle.
  assign pc_out    = (state_q == S_LOAD) ? {24'b0, mem_data} : pc_q;

endmodule
